// File: rtl/shift_reg_seq_ctrl.sv
// Full-duplex shift register engine: loads a word, shifts it out on so while
// capturing si, then presents the captured word with a one-cycle pulse.
module shift_reg_seq_ctrl #(
    parameter int WIDTH     = 4,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    input  logic             si,
    output logic             so,
    output logic             frame,
    input  logic             abort,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int OB = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [GW-1:0]    r_gap;
    logic [WIDTH-1:0] r_po;
    logic             r_po_valid;
    logic [WIDTH-1:0] w_shifted;
    logic             w_last;

    // si always enters at the end opposite the bit being driven out
    always_comb begin
        if (MSB_FIRST) w_shifted = {r_shreg[WIDTH-2:0], si};
        else           w_shifted = {si, r_shreg[WIDTH-1:1]};
    end

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign pi_ready = (r_state == S_IDLE);
    assign busy     = !pi_ready;
    assign frame    = (r_state == S_SHIFT);
    assign so       = frame & r_shreg[OB];
    assign po       = r_po;
    assign po_valid = r_po_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_po       <= '0;
            r_po_valid <= 1'b0;
        end else begin
            r_po_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (pi_valid) begin
                        r_shreg <= pi;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_shreg <= w_shifted;
                        r_cnt   <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_po       <= w_shifted;
                            r_po_valid <= 1'b1;
                            if (GAP == 0) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_GAP;
                                r_gap   <= GW'(GAP);
                            end
                        end
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - GW'(1);
                    if (r_gap == GW'(1)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
